// File: rtl/aximm_patgen_multi.sv
// -----------------------------------------------------------------------------
// aximm_patgen_multi
//
// Multi-lane, multi-mode data-pattern generator for the AXI-MM full examples.
// Each beat carries NUM_LANES words of DATA_WIDTH bits. Lane k is derived
// combinationally from a running base value:
//   mode 0 increment : base + k*step
//   mode 1 decrement : base - k*step
//   mode 2 rotate    : base rotated left by k
//   mode 3 constant  : base
// Seed, step, mode and beat count are captured on the start pulse. A beat is
// presented and transferred on every RUN cycle where the downstream FIFO is
// not full. The base then advances by one beat's worth of lanes.
//
// Optional feature (macro PATGEN_ERR_INJ_EN): adds input err_inj. A pulse
// arms a sticky flag that inverts bit 0 of lane 0 on the next transferred
// beat only. The base register is never corrupted.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   start          single-cycle start pulse (ignored unless idle)
//   stop           abort request (wins over start when idle)
//   seed_in        initial base value
//   step_in        per-lane step, zero-extended
//   mode_in        pattern mode
//   patgen_cnt     beats to generate, 0 = run until stop
//   chkr_fifo_full downstream backpressure
//   err_inj        (PATGEN_ERR_INJ_EN only) single-beat error injection
//   pat_valid      beat presented and accepted this cycle
//   pat_data       beat data, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy           generator is running
//   done           one-cycle pulse when the programmed count completes
// -----------------------------------------------------------------------------
module aximm_patgen_multi #(
  parameter int unsigned DATA_WIDTH = 40,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic [DATA_WIDTH-1:0]           seed_in,
  input  logic [7:0]                      step_in,
  input  logic [1:0]                      mode_in,
  input  logic [CNT_WIDTH-1:0]            patgen_cnt,
  input  logic                            chkr_fifo_full,
`ifdef PATGEN_ERR_INJ_EN
  input  logic                            err_inj,
`endif
  output logic                            pat_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] pat_data,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned BeatWidth = NUM_LANES * DATA_WIDTH;
  localparam int unsigned RotStep   = NUM_LANES % DATA_WIDTH;

  localparam logic [1:0] ModeInc   = 2'd0;
  localparam logic [1:0] ModeDec   = 2'd1;
  localparam logic [1:0] ModeRot   = 2'd2;
  localparam logic [1:0] ModeConst = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  base_q, base_next;
  logic [7:0]             step_q;
  logic [1:0]             mode_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [CNT_WIDTH-1:0]   beat_cnt_q;
  logic [BeatWidth-1:0]   last_q;
  logic [BeatWidth-1:0]   lanes;
  logic [BeatWidth-1:0]   beat;
  logic [DATA_WIDTH-1:0]  step_ext;
  logic [DATA_WIDTH-1:0]  beat_adv;
  logic                   launch;
  logic                   xfer;

  function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned          amt);
    logic [2*DATA_WIDTH-1:0] dbl;
    dbl = {x, x} << (amt % DATA_WIDTH);
    return dbl[2*DATA_WIDTH-1 -: DATA_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_val(input logic [DATA_WIDTH-1:0] base,
                                                     input logic [DATA_WIDTH-1:0] off,
                                                     input logic [1:0]            mode,
                                                     input int unsigned           idx);
    logic [DATA_WIDTH-1:0] v;
    case (mode)
      ModeInc: v = base + off;
      ModeDec: v = base - off;
      ModeRot: v = rotl(base, idx);
      default: v = base;
    endcase
    return v;
  endfunction

  assign step_ext = DATA_WIDTH'(step_q);
  assign beat_adv = DATA_WIDTH'(NUM_LANES) * step_ext;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [DATA_WIDTH-1:0] LaneIdx = DATA_WIDTH'(k);
    logic [DATA_WIDTH-1:0] off;
    assign off = LaneIdx * step_ext;
    assign lanes[k*DATA_WIDTH +: DATA_WIDTH] = lane_val(base_q, off, mode_q, k);
  end

  always_comb begin
    base_next = base_q;
    case (mode_q)
      ModeInc:   base_next = base_q + beat_adv;
      ModeDec:   base_next = base_q - beat_adv;
      ModeRot:   base_next = rotl(base_q, RotStep);
      ModeConst: base_next = base_q;
      default:   base_next = base_q;
    endcase
  end

  // FSM next state and Moore/Mealy outputs.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    pat_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StRun;
          launch  = 1'b1;
        end
      end
      StRun: begin
        busy      = 1'b1;
        pat_valid = !chkr_fifo_full;
        // Stop takes priority: abort without a done pulse even on the last beat.
        if (stop) begin
          state_d = StIdle;
        end else if (pat_valid && (count_q != '0) &&
                     (beat_cnt_q == count_q - CNT_WIDTH'(1))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign xfer = pat_valid;

`ifdef PATGEN_ERR_INJ_EN
  logic err_armed_q, err_armed_d;

  // The flag only lives while running; an injection pulse on a transfer cycle
  // targets the following beat.
  always_comb begin
    beat    = lanes;
    beat[0] = lanes[0] ^ err_armed_q;
    if (state_d == StRun) begin
      err_armed_d = (err_armed_q && !xfer) || err_inj;
    end else begin
      err_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_armed_q <= 1'b0;
    end else begin
      err_armed_q <= err_armed_d;
    end
  end
`else
  assign beat = lanes;
`endif

  // Last presented beat persists while stalled and after the run ends.
  assign pat_data = pat_valid ? beat : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      step_q     <= '0;
      mode_q     <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
      last_q     <= '0;
    end else if (launch) begin
      base_q     <= seed_in;
      step_q     <= step_in;
      mode_q     <= mode_in;
      count_q    <= patgen_cnt;
      beat_cnt_q <= '0;
    end else if (xfer) begin
      base_q     <= base_next;
      beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
      last_q     <= beat;
    end
  end

endmodule

// File: tb/tb_aximm_patgen_multi.sv
module tb_aximm_patgen_multi;

  localparam int unsigned DW = 40;
  localparam int unsigned NL = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = NL * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop;
  logic [DW-1:0] seed_in;
  logic [7:0]    step_in;
  logic [1:0]    mode_in;
  logic [CW-1:0] patgen_cnt;
  logic          chkr_fifo_full;
`ifdef PATGEN_ERR_INJ_EN
  logic          err_inj;
`endif
  logic          pat_valid;
  logic [BW-1:0] pat_data;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [BW-1:0] exp_q[$];

  always #5 clk = ~clk;

  aximm_patgen_multi #(
    .DATA_WIDTH(DW),
    .NUM_LANES (NL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .seed_in       (seed_in),
    .step_in       (step_in),
    .mode_in       (mode_in),
    .patgen_cnt    (patgen_cnt),
    .chkr_fifo_full(chkr_fifo_full),
`ifdef PATGEN_ERR_INJ_EN
    .err_inj       (err_inj),
`endif
    .pat_valid     (pat_valid),
    .pat_data      (pat_data),
    .busy          (busy),
    .done          (done)
  );

  // Reference model: lane k of beat i is the (i*NL+k)-th element of the sequence.
  function automatic logic [BW-1:0] model_beat(input logic [DW-1:0] seed, input logic [7:0] step,
                                               input logic [1:0] mode, input int unsigned idx);
    logic [BW-1:0] r;
    logic [DW-1:0] s, v;
    int unsigned   n;
    s = DW'(step);
    for (int k = 0; k < NL; k++) begin
      n = idx * NL + k;
      case (mode)
        2'd0: v = seed + DW'(n) * s;
        2'd1: v = seed - DW'(n) * s;
        2'd2: begin
          v = seed;
          for (int j = 0; j < int'(n % DW); j++) v = {v[DW-2:0], v[DW-1]};
        end
        default: v = seed;
      endcase
      r[k*DW +: DW] = v;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; chkr_fifo_full = 1'b0;
`ifdef PATGEN_ERR_INJ_EN
    err_inj = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seed_in = '0; step_in = '0; mode_in = '0; patgen_cnt = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (pat_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pat_valid); else n_pass++;
    n_checks++; if (pat_data !== '0) $display("FAIL reset_data: got %h want 0", pat_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_increment();
    int busy_cyc = 0, done_cnt = 0, done_at = -1;
    logic [BW-1:0] e;
    seed_in = 40'h00_0000_0010; step_in = 8'd1; mode_in = 2'd0; patgen_cnt = 8'd3;
    for (int i = 0; i < 3; i++) exp_q.push_back(model_beat(seed_in, step_in, mode_in, i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (pat_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL inc_extra_beat: got %h want none", pat_data);
        else begin
          e = exp_q.pop_front();
          if (pat_data !== e) $display("FAIL inc_beat: got %h want %h", pat_data, e); else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL inc_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (busy_cyc != 3) $display("FAIL inc_busy_cycles: got %0d want 3", busy_cyc); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL inc_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (done_at != 4) $display("FAIL inc_done_cycle: got %0d want 4", done_at); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int done_at = -1;
    logic [BW-1:0] e, frozen;
    seed_in = 40'h00_0000_0010; step_in = 8'd1; mode_in = 2'd0; patgen_cnt = 8'd3;
    frozen = model_beat(seed_in, step_in, mode_in, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(model_beat(seed_in, step_in, mode_in, i));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = (c == 0);
      chkr_fifo_full = (c >= 2 && c <= 4);
      #1;
      if (done === 1'b1) done_at = c;
      if (c >= 2 && c <= 4) begin
        n_checks++; if (pat_valid !== 1'b0) $display("FAIL bp_valid_stall: got %b want 0", pat_valid); else n_pass++;
        n_checks++; if (pat_data !== frozen) $display("FAIL bp_frozen: got %h want %h", pat_data, frozen); else n_pass++;
      end
      if (pat_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra_beat: got %h want none", pat_data);
        else begin
          e = exp_q.pop_front();
          if (pat_data !== e) $display("FAIL bp_beat: got %h want %h", pat_data, e); else n_pass++;
        end
      end
    end
    chkr_fifo_full = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (done_at != 7) $display("FAIL bp_done_cycle: got %0d want 7", done_at); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_decrement();
    int done_at = -1;
    logic [BW-1:0] e, k;
    k = {40'hFF_FFFF_FFFB, 40'hFF_FFFF_FFFD, 40'hFF_FFFF_FFFF, 40'h00_0000_0001};
    seed_in = 40'h00_0000_0001; step_in = 8'd2; mode_in = 2'd1; patgen_cnt = 8'd1;
    exp_q.push_back(model_beat(seed_in, step_in, mode_in, 0));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      if (done === 1'b1) done_at = c;
      if (c == 1) begin
        n_checks++; if (pat_data !== k) $display("FAIL dec_wrap_const: got %h want %h", pat_data, k); else n_pass++;
      end
      if (pat_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL dec_extra_beat: got %h want none", pat_data);
        else begin
          e = exp_q.pop_front();
          if (pat_data !== e) $display("FAIL dec_beat: got %h want %h", pat_data, e); else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL dec_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (done_at != 2) $display("FAIL dec_done_cycle: got %0d want 2", done_at); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_rotate();
    logic [BW-1:0] e;
    seed_in = 40'h80_0000_0001; step_in = 8'd0; mode_in = 2'd2; patgen_cnt = 8'd2;
    for (int i = 0; i < 2; i++) exp_q.push_back(model_beat(seed_in, step_in, mode_in, i));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      if (c == 1) begin
        n_checks++;
        if (pat_data[DW +: DW] !== 40'h00_0000_0003)
          $display("FAIL rot_b0_lane1: got %h want 0000000003", pat_data[DW +: DW]);
        else n_pass++;
      end
      if (c == 2) begin
        n_checks++;
        if (pat_data[0 +: DW] !== 40'h00_0000_0018)
          $display("FAIL rot_b1_lane0: got %h want 0000000018", pat_data[0 +: DW]);
        else n_pass++;
      end
      if (pat_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rot_extra_beat: got %h want none", pat_data);
        else begin
          e = exp_q.pop_front();
          if (pat_data !== e) $display("FAIL rot_beat: got %h want %h", pat_data, e); else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rot_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_continuous_stop();
    int done_cnt = 0;
    int fails = 0;
    logic [BW-1:0] e, last;
    logic [DW-1:0] s0;
    s0 = 40'h00_0000_0000;
    seed_in = s0; step_in = 8'd1; mode_in = 2'd0; patgen_cnt = 8'd0;
    for (int i = 0; i <= 300; i++) exp_q.push_back(model_beat(s0, 8'd1, 2'd0, i));
    last = model_beat(s0, 8'd1, 2'd0, 300);
    for (int c = 0; c <= 301; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == 100);
      if (c == 100) begin
        seed_in = 40'hDE_ADBE_EF00; step_in = 8'd7; mode_in = 2'd2; patgen_cnt = 8'd5;
      end
      stop = (c == 301);
      #1;
      if (done === 1'b1) done_cnt++;
      if (pat_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL cont_extra_beat: got %h want none", pat_data);
        else begin
          e = exp_q.pop_front();
          if (pat_data !== e) begin
            if (fails < 5) $display("FAIL cont_beat: got %h want %h", pat_data, e);
            fails++;
          end else n_pass++;
        end
      end
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    n_checks++; if (exp_q.size() != 0) $display("FAIL cont_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (done_cnt != 0) $display("FAIL cont_done_seen: got %0d want 0", done_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL stop_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL stop_done: got %b want 0", done); else n_pass++;
    n_checks++; if (pat_data !== last) $display("FAIL stop_hold: got %h want %h", pat_data, last); else n_pass++;
    exp_q.delete();
    // start and stop together while idle
    seed_in = 40'h11; step_in = 8'd1; mode_in = 2'd0; patgen_cnt = 8'd2;
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL startstop_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (pat_valid !== 1'b0) $display("FAIL startstop_valid: got %b want 0", pat_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL startstop_busy2: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [BW-1:0] e;
    seed_in = 40'h00_0000_00AB; step_in = 8'd3; mode_in = 2'd3; patgen_cnt = 8'd10;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      if (c >= 1) begin
        e = model_beat(seed_in, step_in, mode_in, c - 1);
        n_checks++; if (pat_data !== e) $display("FAIL rst_run_beat: got %h want %h", pat_data, e); else n_pass++;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (pat_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", pat_valid); else n_pass++;
    n_checks++; if (pat_data !== '0) $display("FAIL rst_mid_data: got %h want 0", pat_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_after: got busy=%b done=%b want 0 0", busy, done); else n_pass++;
  endtask

`ifdef PATGEN_ERR_INJ_EN
  task automatic test_err_inj();
    logic [BW-1:0] e;
    seed_in = 40'h00_0000_0010; step_in = 8'd1; mode_in = 2'd0; patgen_cnt = 8'd4;
    for (int i = 0; i < 4; i++) begin
      e = model_beat(seed_in, step_in, mode_in, i);
      if (i == 1) e[0] = ~e[0];
      exp_q.push_back(e);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start = (c == 0);
      err_inj = (c == 1);
      #1;
      if (pat_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL err_extra_beat: got %h want none", pat_data);
        else begin
          e = exp_q.pop_front();
          if (pat_data !== e) $display("FAIL err_beat: got %h want %h", pat_data, e); else n_pass++;
        end
      end
    end
    err_inj = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL err_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_increment();
    test_backpressure();
    test_decrement();
    test_rotate();
    test_continuous_stop();
`ifdef PATGEN_ERR_INJ_EN
    test_err_inj();
`endif
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
